// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU command issue block: command FIFO, issue FSM, result capture
//
// Build option: define ALU_ISSUE_ZFLAG_EN to add the res_zero output.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_op/cmd_a/cmd_b/cmd_chain payload
//   alu_a/alu_b/alu_op          registered operands and opcode to the external ALU
//   alu_out                     combinational ALU result
//   res_valid/res_ready         result handshake; res_data/res_err payload
//   res_zero                    (ALU_ISSUE_ZFLAG_EN only) captured result is zero
//   busy                        FIFO non-empty or FSM not idle

module alu_issue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign empty = (count == '0);
    // Full comes from the registered count only, so a pop while full
    // does not reopen the port in the same cycle.
    assign full  = (count == (AW+1)'(DEPTH));
endmodule

module alu_issue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
`ifdef ALU_ISSUE_ZFLAG_EN
    output logic             res_zero,
`endif
    output logic             busy
);
    localparam int EW = 2*WIDTH + 6;
    localparam logic [4:0] OP_NOP     = 5'h00;
    localparam logic [4:0] OP_MAX_LEG = 5'h06;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t state;
    state_t state_nxt;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [EW-1:0]         fifo_rdata;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;

    logic                  head_chain;
    logic [4:0]            head_op;
    logic [WIDTH-1:0]      head_a;
    logic [WIDTH-1:0]      head_b;
    logic                  head_legal;

    logic                  illegal;
    logic [WIDTH-1:0]      last_result;
    logic [WIDTH-1:0]      capture;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    alu_issue_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({cmd_chain, cmd_op, cmd_a, cmd_b}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign head_chain = fifo_rdata[EW-1];
    assign head_op    = fifo_rdata[EW-2 -: 5];
    assign head_a     = fifo_rdata[2*WIDTH-1 -: WIDTH];
    assign head_b     = fifo_rdata[WIDTH-1:0];
    assign head_legal = (head_op <= OP_MAX_LEG);

    // Illegal opcodes still run through the ALU as NOP, but the result is
    // forced to zero so nothing opcode-dependent leaks out.
    assign capture = illegal ? '0 : alu_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = HOLD;
            HOLD: if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= OP_NOP;
            illegal     <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_err     <= 1'b0;
            last_result <= '0;
`ifdef ALU_ISSUE_ZFLAG_EN
            res_zero    <= 1'b0;
`endif
        end else begin
            if (fifo_pop) begin
                alu_a   <= head_chain ? last_result : head_a;
                alu_b   <= head_b;
                alu_op  <= head_legal ? head_op : OP_NOP;
                illegal <= !head_legal;
            end
            if (state == EXEC) begin
                res_data    <= capture;
                res_err     <= illegal;
                last_result <= capture;
                res_valid   <= 1'b1;
`ifdef ALU_ISSUE_ZFLAG_EN
                res_zero    <= (capture == '0);
`endif
            end
            if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign busy = (fifo_count != '0) || (state != IDLE);
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Initiator side of the 32-bit ALU interface (a, b, 5-bit op → out). The block:
- Buffers ALU commands arriving on a valid/ready port.
- Drives registered operands and opcode into a combinational ALU instance.
- Captures the ALU result and presents it on a valid/ready result port.
- Optionally chains the previous result in as operand A.

It sits between a host/test sequencer and the ALU.

Parameters:
WIDTH, 32, operand/result width
DEPTH, 4, command FIFO entries (power of 2, ≥2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept command
cmd_op  input  5  ALU opcode
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
cmd_chain  input  1  1 = use last result instead of cmd_a
alu_a  output  WIDTH  registered operand A to ALU
alu_b  output  WIDTH  registered operand B to ALU
alu_op  output  5  registered opcode to ALU
alu_out  input  WIDTH  ALU combinational result
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  captured result
res_err  output  1  result came from illegal opcode
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Clock and reset:
  - One clock, clk. rst_n is asynchronous, active-low.
  - All state is cleared on reset: FIFO empty, FSM IDLE.
  - Reset values: alu_a=0, alu_b=0, alu_op=5'h00, res_valid=0, res_data=0, res_err=0, last_result=0, busy=0.
  - cmd_ready is 1 once reset deasserts.
  - Reset mid-operation discards all queued and in-flight commands; no result is emitted.
- Opcodes:
  - Legal: 00 NOP, 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR, 06 NOR.
  - 07–1F are illegal.
- Command FIFO:
  - DEPTH entries; each entry holds {op, a, b, chain}.
  - cmd_ready = !full, taken from registered count.
  - Push occurs on cmd_valid & cmd_ready.
  - When full, a pop in the same cycle does not raise cmd_ready (no bypass).
  - Simultaneous push and pop keeps count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: if FIFO non-empty, pop head and load alu_a / alu_b / alu_op → EXEC.
    - alu_a = chain ? last_result : a.
    - Illegal op: drive alu_op = 00 and set internal illegal flag.
  - EXEC: one cycle with ALU inputs stable.
    - At the end of the cycle: res_data ← illegal ? 0 : alu_out; res_err ← illegal; last_result ← same value as res_data; res_valid ← 1 → HOLD.
  - HOLD: res_valid, res_data and res_err held stable until res_ready.
    - On res_valid & res_ready: res_valid ← 0 → IDLE.
- Latency:
  - Command accepted in cycle N with FIFO empty and FSM IDLE → popped in N+1 → ALU inputs valid in N+2 → res_valid high from N+3.
  - Throughput: one result per 3 cycles with res_ready held high.
- Chaining:
  - last_result updates only in EXEC.
  - A chained command sees the result of the immediately preceding executed command, including 0 from an illegal one.
- Arithmetic: ADD and SUB wrap modulo 2^WIDTH; the block adds no overflow detection.
- alu_a, alu_b and alu_op hold their last values outside EXEC.
- busy = (count≠0) | (state≠IDLE).

Optional Feature:
- Macro: ALU_ISSUE_ZFLAG_EN.
- Defined: adds output res_zero (1 bit).
  - Registered in EXEC alongside res_data, = (captured value == 0).
  - Held in HOLD; reset value 0.
- Undefined: res_zero port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then single ADD, a=0x00000005, b=0x00000003, res_ready=1 → res_valid 3 cycles after acceptance, res_data=0x00000008, res_err=0.
2. SUB a=0, b=1 → res_data=0xFFFFFFFF. Then chained SUB with b=0xFFFFFFFF (cmd_chain=1) → res_data=0x00000000; res_zero=1 when ALU_ISSUE_ZFLAG_EN is defined.
3. res_ready=0 while pushing DEPTH+2 commands → cmd_ready drops after 5 accepts (4 FIFO entries + 1 in FSM). res_data stable in HOLD. Releasing res_ready drains results in order: AND 0xF0F0&0xFF00=0xF000, OR=0xFFF0, XOR=0x0FF0, NOR=0xFFFF000F.
4. Illegal op 5'h1A with a=b=0x12345678 → alu_op driven 00, res_data=0, res_err=1. Next legal command → res_err=0.
5. rst_n low for 1 cycle while in HOLD with 2 queued commands → res_valid=0, busy=0, alu_op=0 immediately (asynchronous). No stale result appears afterwards; the next ADD 1+1 → 2.
